// File: rtl/execute_issue_if.sv
// Decode/writeback/execute handshake bundle for the execute issue controller.
interface execute_issue_if;
   logic        decValidIn;
   logic        decReadyOut;
   logic        isMulIn;
   logic        isKillIn;
   logic [3:0]  src1RegIn;
   logic        src1ValidIn;
   logic [3:0]  src2RegIn;
   logic        src2ValidIn;
   logic [3:0]  destRegIn;
   logic        destValidIn;
   logic [3:0]  destSpecialIn;
   logic        destSpecialValidIn;
   logic        wbStallIn;
   logic        wbDoneIn;
   logic [3:0]  wbRegIn;
   logic        wbRegValidIn;
   logic [3:0]  wbRegSpecialIn;
   logic        wbRegSpecialValidIn;
   logic        canExecuteOut;
   logic        killOut;
   logic        mulBusyOut;
   logic [15:0] pendingOut;
   logic [1:0]  stateOut;
   logic [31:0] issuedCountOut;
   logic [31:0] stallCountOut;

   // Pipeline side: decode, writeback and observers.
   modport master (
      output decValidIn, isMulIn, isKillIn, src1RegIn, src1ValidIn, src2RegIn, src2ValidIn,
             destRegIn, destValidIn, destSpecialIn, destSpecialValidIn, wbStallIn, wbDoneIn,
             wbRegIn, wbRegValidIn, wbRegSpecialIn, wbRegSpecialValidIn,
      input  decReadyOut, canExecuteOut, killOut, mulBusyOut, pendingOut, stateOut,
             issuedCountOut, stallCountOut
   );

   // Controller side.
   modport slave (
      input  decValidIn, isMulIn, isKillIn, src1RegIn, src1ValidIn, src2RegIn, src2ValidIn,
             destRegIn, destValidIn, destSpecialIn, destSpecialValidIn, wbStallIn, wbDoneIn,
             wbRegIn, wbRegValidIn, wbRegSpecialIn, wbRegSpecialValidIn,
      output decReadyOut, canExecuteOut, killOut, mulBusyOut, pendingOut, stateOut,
             issuedCountOut, stallCountOut
   );
endinterface

// File: rtl/execute_issue_ctrl.sv
// Execute issue controller: holds one decoded instruction, checks the GPR
// scoreboard for RAW/WAW hazards, sequences fixed-latency MULs and raises a
// sticky kill on RET-class opcodes. decReadyOut and canExecuteOut are
// combinational so a hazard-free stream issues one instruction per cycle.
module execute_issue_ctrl #(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned NUM_REGS    = 16
) (
   input logic            clk,
   input logic            reset,
   execute_issue_if.slave bus
);
   localparam int unsigned CNT_W = 32;
   localparam int unsigned MUL_W = 4;
   localparam int unsigned REG_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      MUL_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;

   state_t              state, stateNext;
   logic [NUM_REGS-1:0] pending, pendingNext, setMask, clrMask;
   logic [CNT_W-1:0]    issuedCount, issuedNext, stallCount, stallNext;
   logic [MUL_W-1:0]    mulCnt, mulCntNext;
   logic                killReg, killNext;
   logic                decReady, canExec, mulBusy, hazard, xfer;

   logic                hMul, hKill, hSrc1Valid, hSrc2Valid, hDestValid, hDestSpecialValid;
   logic [REG_W-1:0]    hSrc1, hSrc2, hDest, hDestSpecial;

   assign xfer = bus.decValidIn & decReady;

   // Registered hazard check against the held instruction; retirements this cycle are not bypassed.
   assign hazard = (hSrc1Valid        & pending[hSrc1])
                 | (hSrc2Valid        & pending[hSrc2])
                 | (hDestValid        & pending[hDest])
                 | (hDestSpecialValid & pending[hDestSpecial]);

   // Scoreboard set/clear masks; set wins over a same-edge clear.
   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (hDestValid)        setMask[hDest]        = 1'b1;
      if (hDestSpecialValid) setMask[hDestSpecial] = 1'b1;
      if (bus.wbDoneIn && bus.wbRegValidIn)        clrMask[bus.wbRegIn]        = 1'b1;
      if (bus.wbDoneIn && bus.wbRegSpecialValidIn) clrMask[bus.wbRegSpecialIn] = 1'b1;
   end

   // Next-state, counters and handshake outputs.
   always_comb begin
      stateNext   = state;
      decReady    = 1'b0;
      canExec     = 1'b0;
      mulBusy     = 1'b0;
      issuedNext  = issuedCount;
      stallNext   = stallCount;
      mulCntNext  = mulCnt;
      killNext    = killReg;
      pendingNext = pending & ~clrMask;
      unique case (state)
         IDLE: begin
            decReady = 1'b1;
            if (bus.decValidIn) stateNext = CHECK;
         end
         CHECK: begin
            if (hazard || bus.wbStallIn) begin
               stallNext = stallCount + CNT_W'(1);
            end else if (hMul) begin
               stateNext   = MUL_WAIT;
               mulCntNext  = MUL_W'(MUL_LATENCY - 1);
               pendingNext = (pending & ~clrMask) | setMask;
            end else if (hKill) begin
               canExec    = 1'b1;
               issuedNext = issuedCount + CNT_W'(1);
               stateNext  = HALT;
               killNext   = 1'b1;
            end else begin
               canExec     = 1'b1;
               decReady    = 1'b1;
               issuedNext  = issuedCount + CNT_W'(1);
               pendingNext = (pending & ~clrMask) | setMask;
               stateNext   = bus.decValidIn ? CHECK : IDLE;
            end
         end
         MUL_WAIT: begin
            mulBusy = 1'b1;
            if (mulCnt != '0) begin
               mulCntNext = mulCnt - MUL_W'(1);
            end else if (!bus.wbStallIn) begin
               canExec    = 1'b1;
               issuedNext = issuedCount + CNT_W'(1);
               stateNext  = IDLE;
            end
         end
         HALT: begin
         end
         default: stateNext = IDLE;
      endcase
   end

   // State, scoreboard, counters and holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         pending           <= '0;
         issuedCount       <= '0;
         stallCount        <= '0;
         mulCnt            <= '0;
         killReg           <= 1'b0;
         hMul              <= 1'b0;
         hKill             <= 1'b0;
         hSrc1             <= '0;
         hSrc1Valid        <= 1'b0;
         hSrc2             <= '0;
         hSrc2Valid        <= 1'b0;
         hDest             <= '0;
         hDestValid        <= 1'b0;
         hDestSpecial      <= '0;
         hDestSpecialValid <= 1'b0;
      end else begin
         state       <= stateNext;
         pending     <= pendingNext;
         issuedCount <= issuedNext;
         stallCount  <= stallNext;
         mulCnt      <= mulCntNext;
         killReg     <= killNext;
         if (xfer) begin
            hMul              <= bus.isMulIn;
            hKill             <= bus.isKillIn;
            hSrc1             <= bus.src1RegIn;
            hSrc1Valid        <= bus.src1ValidIn;
            hSrc2             <= bus.src2RegIn;
            hSrc2Valid        <= bus.src2ValidIn;
            hDest             <= bus.destRegIn;
            hDestValid        <= bus.destValidIn;
            hDestSpecial      <= bus.destSpecialIn;
            hDestSpecialValid <= bus.destSpecialValidIn;
         end
      end
   end

   assign bus.decReadyOut    = decReady;
   assign bus.canExecuteOut  = canExec;
   assign bus.mulBusyOut     = mulBusy;
   assign bus.killOut        = killReg;
   assign bus.pendingOut     = pending;
   assign bus.stateOut       = state;
   assign bus.issuedCountOut = issuedCount;
   assign bus.stallCountOut  = stallCount;
endmodule

// File: tb/tb_execute_issue_ctrl.sv
// Directed bench for execute_issue_ctrl with hand-computed expectations.
module tb_execute_issue_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   pass = 0;
   int   total = 0;

   execute_issue_if bus ();

   execute_issue_ctrl #(.MUL_LATENCY(4), .NUM_REGS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.decValidIn = 0; bus.isMulIn = 0; bus.isKillIn = 0;
      bus.src1RegIn = 0; bus.src1ValidIn = 0; bus.src2RegIn = 0; bus.src2ValidIn = 0;
      bus.destRegIn = 0; bus.destValidIn = 0; bus.destSpecialIn = 0; bus.destSpecialValidIn = 0;
      bus.wbStallIn = 0; bus.wbDoneIn = 0; bus.wbRegIn = 0; bus.wbRegValidIn = 0;
      bus.wbRegSpecialIn = 0; bus.wbRegSpecialValidIn = 0;
   endtask

   task automatic present(input logic mul, input logic kill, input logic [3:0] d, input logic dv,
                          input logic [3:0] ds, input logic dsv, input logic [3:0] s1, input logic s1v);
      bus.decValidIn = 1; bus.isMulIn = mul; bus.isKillIn = kill;
      bus.destRegIn = d; bus.destValidIn = dv; bus.destSpecialIn = ds; bus.destSpecialValidIn = dsv;
      bus.src1RegIn = s1; bus.src1ValidIn = s1v; bus.src2RegIn = 0; bus.src2ValidIn = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; cyc(); cyc();
      reset = 0; #1;
      total++; if (bus.decReadyOut !== 1'b1) $display("FAIL rst_ready got %0b want 1", bus.decReadyOut); else pass++;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL rst_exec got %0b want 0", bus.canExecuteOut); else pass++;
      total++; if (bus.mulBusyOut !== 1'b0) $display("FAIL rst_mulbusy got %0b want 0", bus.mulBusyOut); else pass++;
      total++; if (bus.stateOut !== 2'd0) $display("FAIL rst_state got %0d want 0", bus.stateOut); else pass++;
      total++; if (bus.pendingOut !== 16'h0) $display("FAIL rst_pending got %h want 0000", bus.pendingOut); else pass++;
      total++; if (bus.killOut !== 1'b0) $display("FAIL rst_kill got %0b want 0", bus.killOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd0) $display("FAIL rst_issued got %0d want 0", bus.issuedCountOut); else pass++;
   endtask

   task automatic test_back_to_back();
      present(0, 0, 4'd1, 1, 4'd0, 0, 4'd0, 0); #1;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL b2b_idle_exec got %0b want 0", bus.canExecuteOut); else pass++;
      cyc();
      present(0, 0, 4'd2, 1, 4'd0, 0, 4'd0, 0); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL b2b_exec1 got %0b want 1", bus.canExecuteOut); else pass++;
      total++; if (bus.decReadyOut !== 1'b1) $display("FAIL b2b_ready1 got %0b want 1", bus.decReadyOut); else pass++;
      cyc();
      present(0, 0, 4'd3, 1, 4'd0, 0, 4'd0, 0); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL b2b_exec2 got %0b want 1", bus.canExecuteOut); else pass++;
      cyc();
      idle_inputs(); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL b2b_exec3 got %0b want 1", bus.canExecuteOut); else pass++;
      cyc(); #1;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL b2b_exec_end got %0b want 0", bus.canExecuteOut); else pass++;
      total++; if (bus.stateOut !== 2'd0) $display("FAIL b2b_state got %0d want 0", bus.stateOut); else pass++;
      total++; if (bus.pendingOut !== 16'h000E) $display("FAIL b2b_pending got %h want 000e", bus.pendingOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd3) $display("FAIL b2b_issued got %0d want 3", bus.issuedCountOut); else pass++;
   endtask

   task automatic test_raw_hazard();
      present(0, 0, 4'd5, 1, 4'd0, 0, 4'd0, 0);
      cyc();
      present(0, 0, 4'd6, 1, 4'd0, 0, 4'd5, 1); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL raw_add_exec got %0b want 1", bus.canExecuteOut); else pass++;
      cyc();
      idle_inputs(); #1;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL raw_stall1_exec got %0b want 0", bus.canExecuteOut); else pass++;
      total++; if (bus.decReadyOut !== 1'b0) $display("FAIL raw_stall1_ready got %0b want 0", bus.decReadyOut); else pass++;
      total++; if (bus.stateOut !== 2'd1) $display("FAIL raw_stall1_state got %0d want 1", bus.stateOut); else pass++;
      cyc(); #1;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL raw_stall2_exec got %0b want 0", bus.canExecuteOut); else pass++;
      cyc();
      bus.wbDoneIn = 1; bus.wbRegIn = 4'd5; bus.wbRegValidIn = 1; #1;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL raw_retire_cycle_exec got %0b want 0", bus.canExecuteOut); else pass++;
      cyc();
      idle_inputs(); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL raw_issue_exec got %0b want 1", bus.canExecuteOut); else pass++;
      total++; if (bus.stallCountOut !== 32'd3) $display("FAIL raw_stallcount got %0d want 3", bus.stallCountOut); else pass++;
      cyc(); #1;
      total++; if (bus.pendingOut !== 16'h004E) $display("FAIL raw_pending got %h want 004e", bus.pendingOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd5) $display("FAIL raw_issued got %0d want 5", bus.issuedCountOut); else pass++;
   endtask

   task automatic test_scoreboard_clear();
      bus.wbDoneIn = 1; bus.wbRegIn = 4'd1; bus.wbRegValidIn = 1; bus.wbRegSpecialIn = 4'd2; bus.wbRegSpecialValidIn = 1;
      cyc(); #1;
      total++; if (bus.pendingOut !== 16'h0048) $display("FAIL clr_pair got %h want 0048", bus.pendingOut); else pass++;
      bus.wbRegIn = 4'd3; bus.wbRegSpecialIn = 4'd6;
      cyc();
      bus.wbRegIn = 4'd9; bus.wbRegSpecialValidIn = 0;
      cyc(); #1;
      total++; if (bus.pendingOut !== 16'h0000) $display("FAIL clr_noop got %h want 0000", bus.pendingOut); else pass++;
      idle_inputs();
   endtask

   task automatic test_mul();
      present(1, 0, 4'd0, 1, 4'd2, 1, 4'd0, 0);
      cyc();
      idle_inputs(); #1;
      total++; if (bus.stateOut !== 2'd1) $display("FAIL mul_check_state got %0d want 1", bus.stateOut); else pass++;
      total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL mul_check_exec got %0b want 0", bus.canExecuteOut); else pass++;
      cyc();
      for (int i = 1; i <= 4; i++) begin
         #1;
         total++; if (bus.mulBusyOut !== 1'b1) $display("FAIL mul_busy_%0d got %0b want 1", i, bus.mulBusyOut); else pass++;
         total++; if (bus.canExecuteOut !== (i == 4)) $display("FAIL mul_exec_%0d got %0b want %0b", i, bus.canExecuteOut, (i == 4)); else pass++;
         total++; if (bus.pendingOut !== 16'h0005) $display("FAIL mul_pending_%0d got %h want 0005", i, bus.pendingOut); else pass++;
         cyc();
      end
      #1;
      total++; if (bus.mulBusyOut !== 1'b0) $display("FAIL mul_busy_end got %0b want 0", bus.mulBusyOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd6) $display("FAIL mul_issued got %0d want 6", bus.issuedCountOut); else pass++;
   endtask

   task automatic test_mul_wb_stall();
      present(1, 0, 4'd8, 1, 4'd9, 1, 4'd0, 0);
      cyc();
      idle_inputs();
      cyc();
      for (int i = 0; i < 7; i++) begin
         bus.wbStallIn = (i >= 3 && i <= 5); #1;
         total++; if (bus.canExecuteOut !== (i == 6)) $display("FAIL mulst_exec_%0d got %0b want %0b", i, bus.canExecuteOut, (i == 6)); else pass++;
         cyc();
      end
      idle_inputs(); #1;
      total++; if (bus.stateOut !== 2'd0) $display("FAIL mulst_state got %0d want 0", bus.stateOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd7) $display("FAIL mulst_issued got %0d want 7", bus.issuedCountOut); else pass++;
      total++; if (bus.stallCountOut !== 32'd3) $display("FAIL mulst_stallcount got %0d want 3", bus.stallCountOut); else pass++;
      total++; if (bus.pendingOut !== 16'h0305) $display("FAIL mulst_pending got %h want 0305", bus.pendingOut); else pass++;
   endtask

   task automatic test_same_edge();
      present(0, 0, 4'd7, 1, 4'd0, 0, 4'd0, 0);
      cyc();
      idle_inputs();
      bus.wbDoneIn = 1; bus.wbRegIn = 4'd7; bus.wbRegValidIn = 1; #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL same_exec got %0b want 1", bus.canExecuteOut); else pass++;
      cyc();
      idle_inputs(); #1;
      total++; if (bus.pendingOut !== 16'h0385) $display("FAIL same_pending got %h want 0385", bus.pendingOut); else pass++;
   endtask

   task automatic test_kill();
      present(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0);
      cyc();
      present(0, 0, 4'd10, 1, 4'd0, 0, 4'd0, 0); #1;
      total++; if (bus.canExecuteOut !== 1'b1) $display("FAIL kill_exec got %0b want 1", bus.canExecuteOut); else pass++;
      total++; if (bus.decReadyOut !== 1'b0) $display("FAIL kill_check_ready got %0b want 0", bus.decReadyOut); else pass++;
      total++; if (bus.killOut !== 1'b0) $display("FAIL kill_early got %0b want 0", bus.killOut); else pass++;
      cyc();
      bus.wbDoneIn = 1; bus.wbRegIn = 4'd7; bus.wbRegValidIn = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (bus.killOut !== 1'b1) $display("FAIL kill_sticky_%0d got %0b want 1", i, bus.killOut); else pass++;
         total++; if (bus.decReadyOut !== 1'b0) $display("FAIL kill_ready_%0d got %0b want 0", i, bus.decReadyOut); else pass++;
         total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL kill_exec_%0d got %0b want 0", i, bus.canExecuteOut); else pass++;
         cyc();
         bus.wbDoneIn = 0;
      end
      #1;
      total++; if (bus.stateOut !== 2'd3) $display("FAIL kill_state got %0d want 3", bus.stateOut); else pass++;
      total++; if (bus.pendingOut !== 16'h0305) $display("FAIL kill_clear got %h want 0305", bus.pendingOut); else pass++;
      total++; if (bus.issuedCountOut !== 32'd9) $display("FAIL kill_issued got %0d want 9", bus.issuedCountOut); else pass++;
      idle_inputs();
      reset = 1; cyc();
      reset = 0; #1;
      total++; if (bus.killOut !== 1'b0) $display("FAIL kill_reset got %0b want 0", bus.killOut); else pass++;
      total++; if (bus.stateOut !== 2'd0) $display("FAIL kill_reset_state got %0d want 0", bus.stateOut); else pass++;
   endtask

   task automatic test_reset_mid_mul();
      present(1, 0, 4'd4, 1, 4'd0, 0, 4'd0, 0);
      cyc();
      idle_inputs();
      cyc(); cyc();
      reset = 1; #1;
      total++; if (bus.mulBusyOut !== 1'b1) $display("FAIL rmul_busy got %0b want 1", bus.mulBusyOut); else pass++;
      cyc();
      reset = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (bus.canExecuteOut !== 1'b0) $display("FAIL rmul_exec_%0d got %0b want 0", i, bus.canExecuteOut); else pass++;
         cyc();
      end
      #1;
      total++; if (bus.issuedCountOut !== 32'd0) $display("FAIL rmul_issued got %0d want 0", bus.issuedCountOut); else pass++;
      total++; if (bus.pendingOut !== 16'h0000) $display("FAIL rmul_pending got %h want 0000", bus.pendingOut); else pass++;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_raw_hazard();
      test_scoreboard_clear();
      test_mul();
      test_mul_wb_stall();
      test_same_edge();
      test_kill();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
